// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store, with a fixed-latency access sequence IDLE -> BUSY -> RESP.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic       MEM_OP_WORD = 1'b0;
    localparam logic [3:0] LAT_LOAD    = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              last_q,      last_d;
    logic              gnt_q,       gnt_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              we_q,        we_d;
    logic              op_q,        op_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic              busy_q,      busy_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic              mem_op_q,    mem_op_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Next-state, arbitration, capture and next-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        op_d        = op_q;
        rdata_d     = rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_op_d    = 1'b0;
        mem_addr_d  = {ADDR_W{1'b0}};
        mem_wdata_d = {DATA_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    // Under contention the requester not served last wins.
                    if (if_req && d_req) begin
                        gnt_d = ~last_q;
                    end else begin
                        gnt_d = d_req;
                    end
                    last_d = gnt_d;
                    cnt_d  = LAT_LOAD;
                    if (gnt_d) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                        op_d    = d_op;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = {DATA_W{1'b0}};
                        we_d    = 1'b0;
                        op_d    = MEM_OP_WORD;
                    end
                    state_d     = ST_BUSY;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    mem_op_d    = op_d;
                    mem_addr_d  = addr_d;
                    mem_wdata_d = wdata_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d  = ST_RESP;
                    if_ack_d = ~gnt_q;
                    d_ack_d  = gnt_q;
                end else begin
                    // Write strobe was only in the first BUSY cycle.
                    cnt_d       = cnt_q - 4'd1;
                    state_d     = ST_BUSY;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_op_d    = op_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            cnt_q       <= 4'd0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            we_q        <= 1'b0;
            op_q        <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_op_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            op_q        <= op_d;
            rdata_q     <= rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
